// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ALU/branch ops until operands are ready, issues one per cycle.
// Optional RS_AGE_ORDER_EN: issue oldest ready entry instead of lowest index.
module alu_reservation_station #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  op_in,
  input  logic [31:0] value1_in,
  input  logic [31:0] value2_in,
  input  logic [2:0]  query1_in,
  input  logic [2:0]  query2_in,
  input  logic [31:0] imm_in,
  input  logic [2:0]  target_in,
  input  logic        is_branch_in,
  input  logic [2:0]  alu_num,
  input  logic [31:0] alu_value,
  input  logic [2:0]  mem_num,
  input  logic [31:0] mem_value,
  output logic        rs_full,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] alu_imm,
  output logic [2:0]  alu_tag,
  output logic        alu_is_branch
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [4:0] OP_NONE = 5'b11111;

  logic [DEPTH-1:0] r_busy;
  logic [4:0]       r_op  [DEPTH];
  logic [31:0]      r_v1  [DEPTH];
  logic [31:0]      r_v2  [DEPTH];
  logic [31:0]      r_imm [DEPTH];
  logic [2:0]       r_q1  [DEPTH];
  logic [2:0]       r_q2  [DEPTH];
  logic [2:0]       r_tag [DEPTH];
  logic             r_br  [DEPTH];
`ifdef RS_AGE_ORDER_EN
  localparam int AW = $clog2(DEPTH) + 1;
  logic [AW-1:0]    r_age [DEPTH];
  logic [AW-1:0]    w_best_age;
`endif

  logic [4:0]  r_alu_op;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [31:0] r_alu_imm;
  logic [2:0]  r_alu_tag;
  logic        r_alu_br;
  logic        r_full;

  logic          w_iss_vld;
  logic [IW-1:0] w_iss_idx;
  logic          w_free_vld;
  logic [IW-1:0] w_free_idx;
  logic          w_is_mem;
  logic          w_alloc;
  logic [CW-1:0] w_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [34:0]   w_res1;
  logic [34:0]   w_res2;

  // Returns {q, v} after snooping both broadcast buses; ALU bus has priority.
  function automatic logic [34:0] f_snoop(input logic [2:0] q, input logic [31:0] v,
                                          input logic [2:0] an, input logic [31:0] av,
                                          input logic [2:0] mn, input logic [31:0] mv);
    if (q != 3'd0 && q == an)      f_snoop = {3'd0, av};
    else if (q != 3'd0 && q == mn) f_snoop = {3'd0, mv};
    else                           f_snoop = {q, v};
  endfunction

  always_comb begin
    w_iss_vld  = 1'b0;
    w_iss_idx  = '0;
    w_free_vld = 1'b0;
    w_free_idx = '0;
    w_cnt      = '0;
`ifdef RS_AGE_ORDER_EN
    w_best_age = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_cnt = w_cnt + CW'(r_busy[i]);
      if (!r_busy[i] && !w_free_vld) begin
        w_free_vld = 1'b1;
        w_free_idx = IW'(i);
      end
`ifdef RS_AGE_ORDER_EN
      if (r_busy[i] && r_q1[i] == 3'd0 && r_q2[i] == 3'd0 &&
          (!w_iss_vld || r_age[i] > w_best_age)) begin
        w_iss_vld  = 1'b1;
        w_iss_idx  = IW'(i);
        w_best_age = r_age[i];
      end
`else
      if (r_busy[i] && r_q1[i] == 3'd0 && r_q2[i] == 3'd0 && !w_iss_vld) begin
        w_iss_vld = 1'b1;
        w_iss_idx = IW'(i);
      end
`endif
    end
    w_is_mem   = (op_in >= 5'b10010) && (op_in <= 5'b11001);
    w_alloc    = (op_in != OP_NONE) && !w_is_mem && w_free_vld;
    w_cnt_next = w_cnt + CW'(w_alloc) - CW'(w_iss_vld);
    w_res1     = f_snoop(query1_in, value1_in, alu_num, alu_value, mem_num, mem_value);
    w_res2     = f_snoop(query2_in, value2_in, alu_num, alu_value, mem_num, mem_value);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy    <= '0;
      r_alu_op  <= OP_NONE;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_imm <= '0;
      r_alu_tag <= '0;
      r_alu_br  <= 1'b0;
      r_full    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (r_busy[i]) begin
          {r_q1[i], r_v1[i]} <= f_snoop(r_q1[i], r_v1[i], alu_num, alu_value, mem_num, mem_value);
          {r_q2[i], r_v2[i]} <= f_snoop(r_q2[i], r_v2[i], alu_num, alu_value, mem_num, mem_value);
`ifdef RS_AGE_ORDER_EN
          if (r_age[i] != '1) r_age[i] <= r_age[i] + 1'b1;
`endif
        end
      end
      if (w_iss_vld) begin
        r_busy[w_iss_idx] <= 1'b0;
        r_alu_op  <= r_op[w_iss_idx];
        r_alu_a   <= r_v1[w_iss_idx];
        r_alu_b   <= r_v2[w_iss_idx];
        r_alu_imm <= r_imm[w_iss_idx];
        r_alu_tag <= r_tag[w_iss_idx];
        r_alu_br  <= r_br[w_iss_idx];
      end else begin
        r_alu_op  <= OP_NONE;
      end
      // Allocation targets a slot that was free before this edge, never the one being issued.
      if (w_alloc) begin
        r_busy[w_free_idx] <= 1'b1;
        r_op[w_free_idx]   <= op_in;
        {r_q1[w_free_idx], r_v1[w_free_idx]} <= w_res1;
        {r_q2[w_free_idx], r_v2[w_free_idx]} <= w_res2;
        r_imm[w_free_idx]  <= imm_in;
        r_tag[w_free_idx]  <= target_in;
        r_br[w_free_idx]   <= is_branch_in;
`ifdef RS_AGE_ORDER_EN
        r_age[w_free_idx]  <= '0;
`endif
      end
      r_full <= (w_cnt_next >= CW'(DEPTH - 1));
    end
  end

  assign rs_full       = r_full;
  assign alu_op        = r_alu_op;
  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign alu_imm       = r_alu_imm;
  assign alu_tag       = r_alu_tag;
  assign alu_is_branch = r_alu_br;
endmodule
